// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// MEM-stage data-memory access controller. Turns an aligned, non-flushed
// load/store into one transaction on a single-outstanding sram-like bus
// (req/addr_ok/data_ok). It also produces the MEM-stage stall and the
// sign/zero-extended load result.
// Optional feature macro: ADDR_MAP_EN. When defined, kseg0/kseg1 virtual
// addresses (addrM[31:29] = 3'b100 or 3'b101) are fixed-mapped to physical
// addresses by clearing the top three bits.
// WAIT_LIMIT > 0 enables a watchdog. It pulses bus_timeoutM once when a
// transaction has spent WAIT_LIMIT cycles in ADDR+DATA.
module mem_access_ctrl #(
  parameter int unsigned WAIT_LIMIT = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memenM,
  input  logic        memwriteM,
  input  logic [5:0]  alucontrolM,
  input  logic [31:0] addrM,
  input  logic [31:0] writedataM,
  input  logic        laddrerrM,
  input  logic        saddrerrM,
  input  logic        flushM,
  input  logic        pipe_stallM,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        bus_timeoutM
);

  // Memory-op control codes shared with the decoder
  localparam logic [5:0] LB_CONTROL  = 6'h20;
  localparam logic [5:0] LH_CONTROL  = 6'h21;
  localparam logic [5:0] LW_CONTROL  = 6'h23;
  localparam logic [5:0] LBU_CONTROL = 6'h24;
  localparam logic [5:0] LHU_CONTROL = 6'h25;
  localparam logic [5:0] SB_CONTROL  = 6'h28;
  localparam logic [5:0] SH_CONTROL  = 6'h29;
  localparam logic [5:0] SW_CONTROL  = 6'h2B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic        go_s;
  logic        stall_s;
  logic        complete_s;
  logic        flushSeen_s;
  logic        flushed_r;
  logic        dataReq_r;
  logic        dataWr_r;
  logic [1:0]  dataSize_r;
  logic [31:0] dataAddr_r;
  logic [31:0] dataWdata_r;
  logic [5:0]  ctrl_r;
  logic [1:0]  offset_r;
  logic [31:0] readData_r;
  logic        busTimeout_s;

  // Bus transfer size for a memory-op code
  function automatic logic [1:0] sizeOf(input logic [5:0] ctrl);
    case (ctrl)
      LB_CONTROL, LBU_CONTROL, SB_CONTROL: sizeOf = 2'd0;
      LH_CONTROL, LHU_CONTROL, SH_CONTROL: sizeOf = 2'd1;
      default:                             sizeOf = 2'd2;
    endcase
  endfunction

  // Replicate store data across every byte lane the access may hit
  function automatic logic [31:0] storeData(input logic [5:0] ctrl, input logic [31:0] wd);
    case (ctrl)
      SB_CONTROL: storeData = {4{wd[7:0]}};
      SH_CONTROL: storeData = {2{wd[15:0]}};
      default:    storeData = wd;
    endcase
  endfunction

  // Pick the addressed byte/half from the raw word and extend it
  function automatic logic [31:0] extendLoad(input logic [5:0] ctrl, input logic [1:0] off,
                                             input logic [31:0] raw);
    logic [7:0]  b;
    logic [15:0] h;
    b = raw[{off, 3'b000} +: 8];
    h = raw[{off[1], 4'b0000} +: 16];
    case (ctrl)
      LB_CONTROL:  extendLoad = {{24{b[7]}}, b};
      LBU_CONTROL: extendLoad = {24'h000000, b};
      LH_CONTROL:  extendLoad = {{16{h[15]}}, h};
      LHU_CONTROL: extendLoad = {16'h0000, h};
      default:     extendLoad = raw;
    endcase
  endfunction

  // Virtual-to-bus address translation
  function automatic logic [31:0] mapAddr(input logic [31:0] va);
`ifdef ADDR_MAP_EN
    if ((va[31:29] == 3'b100) || (va[31:29] == 3'b101)) begin
      mapAddr = {3'b000, va[28:0]};
    end else begin
      mapAddr = va;
    end
`else
    mapAddr = va;
`endif
  endfunction

  assign go_s        = memenM & ~laddrerrM & ~saddrerrM & ~flushM;
  assign flushSeen_s = flushed_r | flushM;
  assign complete_s  = ((state_r == ADDR) && data_addr_ok && data_data_ok) ||
                       ((state_r == DATA) && data_data_ok);

  // Next-state and stall decode
  always_comb begin
    state_s = state_r;
    stall_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (go_s) begin
          state_s = ADDR;
          stall_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      ADDR: begin
        stall_s = 1'b1;
        if (data_addr_ok && data_data_ok) begin
          state_s = flushSeen_s ? IDLE : DONE;
        end else if (data_addr_ok) begin
          state_s = DATA;
        end else begin
          state_s = ADDR;
        end
      end
      DATA: begin
        stall_s = 1'b1;
        if (data_data_ok) begin
          state_s = flushSeen_s ? IDLE : DONE;
        end else begin
          state_s = DATA;
        end
      end
      DONE: begin
        stall_s = 1'b0;
        if (!pipe_stallM) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
        stall_s = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Bus request/attribute registers: latched on go, request dropped on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dataReq_r   <= 1'b0;
      dataWr_r    <= 1'b0;
      dataSize_r  <= 2'd0;
      dataAddr_r  <= 32'h0000_0000;
      dataWdata_r <= 32'h0000_0000;
      ctrl_r      <= 6'h00;
      offset_r    <= 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (go_s) begin
            dataReq_r   <= 1'b1;
            dataWr_r    <= memwriteM;
            dataSize_r  <= sizeOf(alucontrolM);
            dataAddr_r  <= mapAddr(addrM);
            dataWdata_r <= storeData(alucontrolM, writedataM);
            ctrl_r      <= alucontrolM;
            offset_r    <= addrM[1:0];
          end else begin
            dataReq_r <= 1'b0;
          end
        end
        ADDR: begin
          if (data_addr_ok) begin
            dataReq_r <= 1'b0;
          end
        end
        default: begin
          dataReq_r <= 1'b0;
        end
      endcase
    end
  end

  // Remember a flush that arrives while the transaction cannot be withdrawn
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flushed_r <= 1'b0;
    end else if ((state_r == ADDR) || (state_r == DATA)) begin
      flushed_r <= flushed_r | flushM;
    end else begin
      flushed_r <= 1'b0;
    end
  end

  // Load result: capture at completion of a live load, zero on a blocked access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readData_r <= 32'h0000_0000;
    end else if (complete_s && !dataWr_r && !flushSeen_s) begin
      readData_r <= extendLoad(ctrl_r, offset_r, data_rdata);
    end else if ((state_r == IDLE) && memenM && !go_s) begin
      readData_r <= 32'h0000_0000;
    end
  end

  generate
    if (WAIT_LIMIT > 0) begin : gWatchdog
      localparam int unsigned CNT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
      localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(WAIT_LIMIT);
      logic [CNT_W-1:0] waitCnt_r;
      logic [CNT_W-1:0] waitCnt_s;
      logic             inWait_s;
      logic             nextWait_s;
      logic             timeout_r;

      assign inWait_s   = (state_r == ADDR) || (state_r == DATA);
      assign nextWait_s = (state_s == ADDR) || (state_s == DATA);

      // Counter holds the number of ADDR/DATA cycles including the current one
      always_comb begin
        waitCnt_s = waitCnt_r;
        if (!nextWait_s) begin
          waitCnt_s = {CNT_W{1'b0}};
        end else if (!inWait_s) begin
          waitCnt_s = CNT_W'(1);
        end else if (waitCnt_r == LIMIT_C) begin
          waitCnt_s = waitCnt_r;
        end else begin
          waitCnt_s = waitCnt_r + CNT_W'(1);
        end
      end

      // Watchdog counter and single-cycle timeout pulse on reaching the limit
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          waitCnt_r <= {CNT_W{1'b0}};
          timeout_r <= 1'b0;
        end else begin
          waitCnt_r <= waitCnt_s;
          timeout_r <= (waitCnt_s == LIMIT_C) && (waitCnt_r != LIMIT_C);
        end
      end

      assign busTimeout_s = timeout_r;
    end else begin : gNoWatchdog
      assign busTimeout_s = 1'b0;
    end
  endgenerate

  assign data_req     = dataReq_r;
  assign data_wr      = dataWr_r;
  assign data_size    = dataSize_r;
  assign data_addr    = dataAddr_r;
  assign data_wdata   = dataWdata_r;
  assign readdataM    = readData_r;
  assign stallM       = stall_s & ~rst;
  assign bus_timeoutM = busTimeout_s;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl (WAIT_LIMIT = 4).
// Each access is described by its bus schedule: addr_ok latency, data_ok
// latency, DONE hold length and an optional flush cycle. The expected
// per-cycle outputs follow directly from that schedule.
module tb_mem_access_ctrl;

  localparam int WL = 4;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  logic        clk = 1'b0;
  logic        rst;
  logic        memenM, memwriteM;
  logic [5:0]  alucontrolM;
  logic [31:0] addrM, writedataM;
  logic        laddrerrM, saddrerrM, flushM, pipe_stallM;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] readdataM;
  logic        stallM, bus_timeoutM;

  int nCmp = 0;
  int nBad = 0;
  logic [31:0] rdModel;
  logic [5:0]  opTab [8] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};

  always #5 clk = ~clk;

  mem_access_ctrl #(.WAIT_LIMIT(WL)) dut (
    .clk(clk), .rst(rst),
    .memenM(memenM), .memwriteM(memwriteM), .alucontrolM(alucontrolM),
    .addrM(addrM), .writedataM(writedataM),
    .laddrerrM(laddrerrM), .saddrerrM(saddrerrM),
    .flushM(flushM), .pipe_stallM(pipe_stallM),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .readdataM(readdataM), .stallM(stallM), .bus_timeoutM(bus_timeoutM)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic isStore(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [1:0] refSize(input logic [5:0] op);
    if ((op == OP_LB) || (op == OP_LBU) || (op == OP_SB)) return 2'd0;
    if ((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [31:0] refWdata(input logic [5:0] op, input logic [31:0] wd);
    if (op == OP_SB) return (wd & 32'h0000_00FF) * 32'h0101_0101;
    if (op == OP_SH) return (wd & 32'h0000_FFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] refLoad(input logic [5:0] op, input logic [31:0] addr,
                                          input logic [31:0] raw);
    int unsigned bsh, hsh;
    logic [31:0] b, h;
    bsh = 8 * int'(addr[1:0]);
    hsh = 16 * int'(addr[1]);
    b = (raw >> bsh) & 32'h0000_00FF;
    h = (raw >> hsh) & 32'h0000_FFFF;
    if (op == OP_LB)  return (b >= 32'h0000_0080) ? b + 32'hFFFF_FF00 : b;
    if (op == OP_LBU) return b;
    if (op == OP_LH)  return (h >= 32'h0000_8000) ? h + 32'hFFFF_0000 : h;
    if (op == OP_LHU) return h;
    return raw;
  endfunction

  function automatic logic [31:0] refAddr(input logic [31:0] va);
`ifdef ADDR_MAP_EN
    if ((va >= 32'h8000_0000) && (va < 32'hC000_0000)) return va - 32'h8000_0000 - ((va >= 32'hA000_0000) ? 32'h2000_0000 : 32'h0);
`endif
    return va;
  endfunction

  task automatic setIdle();
    memenM       = 1'b0;
    memwriteM    = 1'($urandom);
    alucontrolM  = 6'($urandom);
    addrM        = $urandom;
    writedataM   = $urandom;
    laddrerrM    = 1'b0;
    saddrerrM    = 1'b0;
    flushM       = 1'b0;
    pipe_stallM  = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = $urandom;
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_req"},     32'(data_req), 32'h0);
    check({tag, "_wr"},      32'(data_wr), 32'h0);
    check({tag, "_size"},    32'(data_size), 32'h0);
    check({tag, "_addr"},    data_addr, 32'h0);
    check({tag, "_wdata"},   data_wdata, 32'h0);
    check({tag, "_rd"},      readdataM, 32'h0);
    check({tag, "_stall"},   32'(stallM), 32'h0);
    check({tag, "_timeout"}, 32'(bus_timeoutM), 32'h0);
  endtask

  // One access. a: extra ADDR cycles before addr_ok, d: cycles from accept to
  // data_ok (0 = same cycle), p: DONE cycles held by pipe_stallM, f: flush cycle (0 = none).
  // Called and returns at posedge+1 with the DUT idle.
  task automatic doXfer(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] raw, input int a, input int d, input int p, input int f);
    int c, last;
    logic wr, expReq, expStall, expTo;
    logic [31:0] newRd, expRd;
    wr    = isStore(op);
    c     = a + 1 + d;
    newRd = (wr || (f != 0)) ? rdModel : refLoad(op, addr, raw);
    last  = (f != 0) ? c + 2 : c + 2 + p;
    for (int k = 0; k <= last; k++) begin
      memenM       = (f != 0) ? (k <= f) : (k <= c + 1 + p);
      memwriteM    = wr;
      alucontrolM  = memenM ? op : 6'($urandom);
      addrM        = memenM ? addr : $urandom;
      writedataM   = memenM ? wd : $urandom;
      laddrerrM    = 1'b0;
      saddrerrM    = 1'b0;
      flushM       = (f != 0) && (k == f);
      data_addr_ok = (k == a + 1);
      data_data_ok = (k == c);
      data_rdata   = (k == c) ? raw : $urandom;
      if (k <= c) pipe_stallM = 1'($urandom);
      else        pipe_stallM = (f == 0) && (k < c + 1 + p);
      @(negedge clk);
      expStall = (k <= c);
      expReq   = (k >= 1) && (k <= a + 1);
      expRd    = (k <= c) ? rdModel : newRd;
      expTo    = (k == WL) && (c >= WL);
      check($sformatf("stall op=%h k=%0d", op, k), 32'(stallM), 32'(expStall));
      check($sformatf("req op=%h k=%0d", op, k), 32'(data_req), 32'(expReq));
      check($sformatf("rd op=%h k=%0d", op, k), readdataM, expRd);
      check($sformatf("timeout k=%0d c=%0d", k, c), 32'(bus_timeoutM), 32'(expTo));
      if (expReq) begin
        check($sformatf("wr op=%h k=%0d", op, k), 32'(data_wr), 32'(wr));
        check($sformatf("size op=%h k=%0d", op, k), 32'(data_size), 32'(refSize(op)));
        check($sformatf("addr op=%h k=%0d", op, k), data_addr, refAddr(addr));
        if (wr) check($sformatf("wdata op=%h k=%0d", op, k), data_wdata, refWdata(op, wd));
      end
      @(posedge clk); #1;
    end
    rdModel = newRd;
    setIdle();
  endtask

  // Access blocked in IDLE by an address error or flush. kind: 0 laddr, 1 saddr, 2 flush
  task automatic doErr(input logic [5:0] op, input logic [31:0] addr, input int kind);
    memenM      = 1'b1;
    memwriteM   = isStore(op);
    alucontrolM = op;
    addrM       = addr;
    writedataM  = $urandom;
    laddrerrM   = (kind == 0);
    saddrerrM   = (kind == 1);
    flushM      = (kind == 2);
    @(negedge clk);
    check($sformatf("err%0d_stall", kind), 32'(stallM), 32'h0);
    check($sformatf("err%0d_req", kind), 32'(data_req), 32'h0);
    @(posedge clk); #1;
    setIdle();
    @(negedge clk);
    check($sformatf("err%0d_rd", kind), readdataM, 32'h0);
    check($sformatf("err%0d_req_after", kind), 32'(data_req), 32'h0);
    check($sformatf("err%0d_stall_after", kind), 32'(stallM), 32'h0);
    @(posedge clk); #1;
    rdModel = 32'h0;
  endtask

  task automatic doMidReset();
    memenM      = 1'b1;
    memwriteM   = 1'b0;
    alucontrolM = OP_LW;
    addrM       = 32'h0000_0200;
    @(negedge clk);
    check("midrst_stall_go", 32'(stallM), 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_req", 32'(data_req), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    checkResetOutputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    setIdle();
    rdModel = 32'h0;
    @(negedge clk);
    check("midrst_idle_req", 32'(data_req), 32'h0);
    check("midrst_idle_stall", 32'(stallM), 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [5:0]  op;
    logic [31:0] addr;
    int a, d, p, f, c;
    rst = 1'b1;
    setIdle();
    rdModel = 32'h0;
    @(negedge clk);
    checkResetOutputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    doXfer(OP_LB, 32'h0000_0003, 32'h0, 32'h80FF_FF7F, 0, 2, 0, 0);
    check("lb_result", readdataM, 32'hFFFF_FF80);
    doXfer(OP_LBU, 32'h0000_0003, 32'h0, 32'h80FF_FF7F, 0, 2, 0, 0);
    check("lbu_result", readdataM, 32'h0000_0080);
    doXfer(OP_SH, 32'h0000_0002, 32'h1234_ABCD, $urandom, 0, 0, 0, 0);
    check("sh_keeps_rd", readdataM, 32'h0000_0080);
    doErr(OP_LW, 32'h0000_0006, 0);
    doXfer(OP_LW, 32'h0000_0100, 32'h0, 32'h1111_2222, 1, 1, 0, 0);
    check("lw_result", readdataM, 32'h1111_2222);
    doXfer(OP_LW, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 0, 2, 0, 2);
    check("flush_keeps_rd", readdataM, 32'h1111_2222);
    doXfer(OP_LW, 32'h0000_0108, 32'h0, 32'hCAFE_F00D, 0, 1, 3, 0);
    doXfer(OP_LW, 32'h0000_010C, 32'h0, 32'h0BAD_F00D, 0, 10, 0, 0);
    check("watchdog_lw_result", readdataM, 32'h0BAD_F00D);
    doXfer(OP_LW, 32'hBFC0_0000, 32'h0, 32'h1357_9BDF, 0, 0, 1, 0);
    doXfer(OP_LH, 32'h0000_0012, 32'h0, 32'h8001_7FFF, 2, 3, 0, 0);
    check("lh_result", readdataM, 32'hFFFF_8001);
    doErr(OP_SW, 32'h0000_0021, 1);
    doXfer(OP_SB, 32'h0000_0031, 32'hAAAA_AA5C, $urandom, 0, 1, 0, 0);
    doErr(OP_LB, 32'h0000_0040, 2);
    doXfer(OP_LHU, 32'h0000_0052, 32'h0, 32'h9ABC_0000, 0, 0, 0, 0);
    doMidReset();

    for (int i = 0; i < 40; i++) begin
      op   = opTab[$urandom_range(7)];
      addr = $urandom;
      if (refSize(op) == 2'd2) addr[1:0] = 2'b00;
      if (refSize(op) == 2'd1) addr[0] = 1'b0;
      a = $urandom_range(3);
      d = $urandom_range(5);
      p = $urandom_range(3);
      c = a + 1 + d;
      f = ($urandom_range(4) == 0) ? int'($urandom_range(c, 1)) : 0;
      doXfer(op, addr, $urandom, $urandom, a, d, p, f);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
